periferico_mult_n: RTL
======================

PERIFERICO_MULT_N -- requirements
Module: periferico_mult_n

Interface
REQ-001 The block SHALL have parameter W, default 16, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port d_in, input, 32 bits: write data from the processor.
REQ-005 The block SHALL have port cs, input, 1 bit: chip select; rd and wr are ignored while cs=0.
REQ-006 The block SHALL have port addr, input, 5 bits: register address.
REQ-007 The block SHALL have port rd, input, 1 bit: read strobe.
REQ-008 The block SHALL have port wr, input, 1 bit: write strobe.
REQ-009 The block SHALL have port d_out, output, 32 bits: registered read data.
REQ-010 The block SHALL have port irq, output, 1 bit: interrupt, equal to done AND ie, registered.

Function
REQ-011 The register map SHALL be:
- 0x04 A (RW, bits W-1:0)
- 0x08 B (RW, bits W-1:0)
- 0x0C CTRL (W): bit0 start, bit1 sgn, bit2 err_clr, bit3 ie
- 0x10 RES_LO (R, result bits 31:0)
- 0x14 STATUS (R): bit0 done, bit1 busy, bit2 err
- 0x18 RES_HI (R, result bits 63:32)
REQ-012 Writes (cs=1, wr=1) SHALL take d_in[W-1:0] into A/B and ignore the upper bits; reads of A/B SHALL return the value zero-extended to 32 bits.
REQ-013 The ie and sgn CTRL bits SHALL be stored on every CTRL write; start and err_clr SHALL be self-clearing pulses.
REQ-014 The multiplier SHALL be an iterative shift-add FSM with states IDLE, RUN and DONE.
REQ-015 The FSM SHALL accept a start write in IDLE or DONE: on that edge (E0) it copies A, B and sgn into working registers, clears done, sets busy, loads cnt=0 and enters RUN.
REQ-016 In RUN the FSM SHALL process one multiplier bit per edge; the edges E1..EW perform the W iterations.
REQ-017 On edge E(W+1) the FSM SHALL write the 64-bit result register, set done, clear busy and enter DONE; the fixed latency is W+1 edges after the start edge.
REQ-018 In unsigned mode the product SHALL be the 2W-bit unsigned product, zero-extended to 64 bits.
REQ-019 In signed mode the operands SHALL be two's complement; the FSM multiplies the magnitudes and negates the result if the signs differ, and the 2W-bit product is sign-extended to 64 bits.
REQ-020 In signed mode the most-negative operand SHALL be handled correctly (magnitude 2^(W-1) is held in W unsigned bits).
REQ-021 A start write while busy SHALL be ignored for the running operation and SHALL set the sticky err bit.
REQ-022 err SHALL be cleared only by an err_clr write or by reset; when err_clr and a start-while-busy occur on the same edge, err SHALL be set.
REQ-023 Writes to A/B during RUN SHALL update A/B but SHALL NOT affect the running operation.
REQ-024 The result register and done SHALL hold in DONE until the next accepted start; done SHALL be cleared on the start edge.
REQ-025 A read (cs=1, rd=1) SHALL update d_out on the next edge; reads of unmapped addresses, and of CTRL, SHALL return 0.
REQ-026 d_out SHALL hold its value when no read occurs; if wr and rd are both asserted, the write SHALL take effect and d_out SHALL return the pre-write value.
REQ-027 irq SHALL assert on the edge after done sets if ie=1, and SHALL deassert on the edge after done clears or ie is written 0.

Reset
REQ-028 When reset=0 at an edge, the block SHALL clear A, B, CTRL bits, the working registers, cnt, the result register, done, busy, err, d_out and irq to 0, and set the state to IDLE.
REQ-029 A reset during RUN SHALL abort the operation with no result written; the first start after reset SHALL behave normally.

Verification
REQ-030 W=16, unsigned: A=0xFFFF, B=0xFFFF, start -> busy for 16 edges, done=1 at E17, RES_LO=0xFFFE0001, RES_HI=0.
REQ-031 W=16, signed: A=0xFFFD (-3), B=0x0005, start -> RES_LO=0xFFFFFFF1, RES_HI=0xFFFFFFFF; A=B=0x8000 -> RES_LO=0x40000000, RES_HI=0.
REQ-032 W=16: start on 3x4, second start with A=7 at E5 -> result 12, err=1; err_clr write -> err=0.
REQ-033 W=16: start, reset=0 at E8 -> done=0, busy=0, RES_LO=0; next start on 2x3 -> 6 at E17.
REQ-034 W=32 instance, unsigned: 0xFFFFFFFF x 2 -> RES_LO=0xFFFFFFFE, RES_HI=0x00000001, done at E33.
REQ-035 With ie=1: irq=1 one edge after done; start -> irq=0 one edge after done clears; ie=0 -> irq never asserts.

Source files
------------

// File: rtl/periferico_mult_n.sv
// Memory-mapped iterative W x W shift-add multiplier (unsigned or two's complement), result ready W+1 edges after start.
// Bus accesses never stall; a start while busy is dropped and raises sticky err.
module periferico_mult_n #(
  parameter int W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  output logic        irq
);

  localparam logic [4:0] ADDR_A      = 5'h04;
  localparam logic [4:0] ADDR_B      = 5'h08;
  localparam logic [4:0] ADDR_CTRL   = 5'h0C;
  localparam logic [4:0] ADDR_RES_LO = 5'h10;
  localparam logic [4:0] ADDR_STATUS = 5'h14;
  localparam logic [4:0] ADDR_RES_HI = 5'h18;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_sgn;
  logic           r_ie;
  logic           r_err;
  logic           r_done;
  logic           r_busy;
  logic           r_irq;
  logic [63:0]    r_res;
  logic [31:0]    r_dout;

  logic [2*W-1:0] r_mcand;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_mplier;
  logic           r_neg;
  logic           r_wsgn;
  logic [5:0]     r_cnt;

  logic           w_wr;
  logic           w_rd;
  logic           w_wr_ctrl;
  logic           w_start;
  logic           w_err_clr;
  logic           w_accept;
  logic           w_collide;
  logic           w_last;
  logic           w_sgn_eff;
  logic [W-1:0]   w_a_mag;
  logic [W-1:0]   w_b_mag;
  logic [2*W-1:0] w_prod;
  logic signed [63:0] w_res_sx;
  logic [63:0]    w_res_zx;
  logic [63:0]    w_res;
  logic [31:0]    w_rdata;
  logic           w_unused;

  assign w_wr      = cs && wr;
  assign w_rd      = cs && rd;
  assign w_wr_ctrl = w_wr && (addr == ADDR_CTRL);
  assign w_start   = w_wr_ctrl && d_in[0];
  assign w_err_clr = w_wr_ctrl && d_in[2];
  assign w_accept  = w_start && (r_state != RUN);
  assign w_collide = w_start && (r_state == RUN);
  assign w_last    = (r_state == RUN) && (r_cnt == 6'(W));
  assign w_unused  = ^d_in;

  // A start always arrives with a CTRL write, so the sgn bit of that same write applies.
  assign w_sgn_eff = w_wr_ctrl ? d_in[1] : r_sgn;

  // Magnitude of the most-negative operand is 2^(W-1), which still fits W unsigned bits.
  assign w_a_mag = (w_sgn_eff && r_a[W-1]) ? -r_a : r_a;
  assign w_b_mag = (w_sgn_eff && r_b[W-1]) ? -r_b : r_b;

  assign w_prod   = r_neg ? -r_acc : r_acc;
  assign w_res_sx = 64'($signed(w_prod));
  assign w_res_zx = 64'(w_prod);
  assign w_res    = r_wsgn ? w_res_sx : w_res_zx;

  always_comb begin
    w_rdata = '0;
    case (addr)
      ADDR_A:      w_rdata = 32'(r_a);
      ADDR_B:      w_rdata = 32'(r_b);
      ADDR_RES_LO: w_rdata = r_res[31:0];
      ADDR_STATUS: w_rdata = {29'd0, r_err, r_busy, r_done};
      ADDR_RES_HI: w_rdata = r_res[63:32];
      default:     w_rdata = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    if (w_start) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sgn    <= 1'b0;
      r_ie     <= 1'b0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_irq    <= 1'b0;
      r_res    <= '0;
      r_dout   <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_wsgn   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_wr && (addr == ADDR_A)) r_a <= d_in[W-1:0];
      if (w_wr && (addr == ADDR_B)) r_b <= d_in[W-1:0];
      if (w_wr_ctrl) begin
        r_sgn <= d_in[1];
        r_ie  <= d_in[3];
      end

      // A colliding start wins over a simultaneous err_clr.
      if (w_collide) begin
        r_err <= 1'b1;
      end else if (w_err_clr) begin
        r_err <= 1'b0;
      end

      r_irq <= r_done && r_ie;

      // Read data comes from the pre-edge registers, so a combined rd+wr returns the old value.
      if (w_rd) r_dout <= w_rdata;

      if (w_accept) begin
        r_mcand  <= {{W{1'b0}}, w_a_mag};
        r_mplier <= w_b_mag;
        r_acc    <= '0;
        r_neg    <= w_sgn_eff && (r_a[W-1] ^ r_b[W-1]);
        r_wsgn   <= w_sgn_eff;
        r_cnt    <= '0;
        r_done   <= 1'b0;
        r_busy   <= 1'b1;
      end else if (w_last) begin
        r_res  <= w_res;
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end else if (r_state == RUN) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 6'd1;
      end
    end
  end

  assign d_out = r_dout;
  assign irq   = r_irq;

endmodule
